// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port RAM with a shared tristate data bus.
// Define RAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority; round-robin otherwise.
module ram_port_arbiter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [DATA_W-1:0] ram_data,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                win_b_q, win_b_d;
   logic                a_ack_q, a_ack_d;
   logic                b_ack_q, b_ack_d;
   logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
   logic                busy_q, busy_d;
   logic                grant_b;

`ifdef RAM_ARB_FIXED_PRIO_EN
   assign grant_b = b_req & ~a_req;
`else
   logic                last_b_q, last_b_d;

   // On a tie the requester that was not served last takes the port.
   assign grant_b = b_req & (~a_req | ~last_b_q);
`endif

   always_comb begin
      state_d    = state_q;
      ram_we_d   = ram_we_q;
      ram_addr_d = ram_addr_q;
      wdata_d    = wdata_q;
      win_b_d    = win_b_q;
      a_ack_d    = 1'b0;
      b_ack_d    = 1'b0;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_b_d   = last_b_q;
`endif
      case (state_q)
         ST_IDLE: begin
            ram_we_d = 1'b0;
            if (a_req || b_req) begin
               state_d    = ST_ACCESS;
               win_b_d    = grant_b;
               ram_we_d   = grant_b ? b_we    : a_we;
               ram_addr_d = grant_b ? b_addr  : a_addr;
               wdata_d    = grant_b ? b_wdata : a_wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
               last_b_d   = grant_b;
`endif
            end
         end
         ST_ACCESS: begin
            // The write lands at this edge, so its ack can follow directly.
            ram_we_d = 1'b0;
            if (ram_we_q) begin
               state_d = ST_DONE;
               a_ack_d = ~win_b_q;
               b_ack_d = win_b_q;
            end else begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            state_d = ST_DONE;
            if (win_b_q) begin
               b_rdata_d = ram_data;
               b_ack_d   = 1'b1;
            end else begin
               a_rdata_d = ram_data;
               a_ack_d   = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            ram_we_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         wdata_q    <= '0;
         win_b_q    <= 1'b0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
         busy_q     <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
         last_b_q   <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         wdata_q    <= wdata_d;
         win_b_q    <= win_b_d;
         a_ack_q    <= a_ack_d;
         b_ack_q    <= b_ack_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
         busy_q     <= busy_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
         last_b_q   <= last_b_d;
`endif
      end
   end

   // The RAM owns the bus whenever write enable is low.
   assign ram_data = ram_we_q ? wdata_q : 'z;

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign a_ack    = a_ack_q;
   assign b_ack    = b_ack_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM stub, transaction-level model, per-cycle compare, directed tests.
module tb_ram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_req, a_we, b_req, b_we;
   logic [3:0] a_addr, b_addr;
   logic [7:0] a_wdata, b_wdata;
   logic       a_ack, b_ack;
   logic [7:0] a_rdata, b_rdata;
   logic       ram_we;
   logic [3:0] ram_addr;
   wire  [7:0] ram_data;
   logic       busy;

   int n_checks = 0;
   int n_fails  = 0;

   ram_port_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM stub: synchronous write, registered read word driven whenever we is low.
   logic [7:0] ram_mem [16];
   logic [7:0] ram_rd;
   initial begin
      for (int i = 0; i < 16; i++) ram_mem[i] = 8'h00;
      ram_rd = 8'h00;
   end
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_data;
      else        ram_rd <= ram_mem[ram_addr];
   end
   assign ram_data = ram_we ? 8'bz : ram_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: a granted command occupies the port for a fixed number
   // of cycles (write 2, read 3); ack is due in its final busy cycle.
   int         left = 0;
   int         cur_w = 0;
   int         last_w = 1;
   logic       cur_we = 1'b0;
   logic [3:0] cur_addr = 4'h0;
   logic [7:0] cur_wd = 8'h00;
   logic [7:0] mem_m [16];
   logic [7:0] exp_rd [2];
   initial begin
      for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         left      = 0;
         last_w    = 1;
         exp_rd[0] = 8'h00;
         exp_rd[1] = 8'h00;
      end else if (left > 0) begin
         left = left - 1;
         if (left == 1) begin
            if (cur_we) mem_m[cur_addr] = cur_wd;
            else        exp_rd[cur_w] = mem_m[cur_addr];
         end
      end else if (a_req || b_req) begin
         if (a_req && b_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            cur_w = 0;
`else
            cur_w = (last_w == 1) ? 0 : 1;
`endif
         end else begin
            cur_w = a_req ? 0 : 1;
         end
         last_w   = cur_w;
         cur_we   = (cur_w == 0) ? a_we    : b_we;
         cur_addr = (cur_w == 0) ? a_addr  : b_addr;
         cur_wd   = (cur_w == 0) ? a_wdata : b_wdata;
         left     = cur_we ? 2 : 3;
      end
   end

   int order [$];
   int b_ack_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         chk("a_ack",   a_ack,   (left == 1 && cur_w == 0));
         chk("b_ack",   b_ack,   (left == 1 && cur_w == 1));
         chk("busy",    busy,    (left > 0));
         chk("ram_we",  ram_we,  (left == 2 && cur_we));
         chk("a_rdata", a_rdata, exp_rd[0]);
         chk("b_rdata", b_rdata, exp_rd[1]);
         if (left > 0) chk("ram_addr", ram_addr, cur_addr);
         if (left == 2 && cur_we)  chk("ram_data_wr", ram_data, cur_wd);
         if (left == 2 && !cur_we) chk("ram_data_rd", ram_data, mem_m[cur_addr]);
         if (a_ack === 1'b1) order.push_back(0);
         if (b_ack === 1'b1) begin
            order.push_back(1);
            b_ack_cnt++;
         end
      end
   end

   task automatic do_cmd(input int r, input logic w, input logic [3:0] ad,
                         input logic [7:0] wd, output int lat, output logic [7:0] rd);
      logic got;
      lat = 0;
      got = 1'b0;
      if (r == 0) begin a_we = w; a_addr = ad; a_wdata = wd; a_req = 1'b1; end
      else        begin b_we = w; b_addr = ad; b_wdata = wd; b_req = 1'b1; end
      while (!got && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         got = (r == 0) ? a_ack : b_ack;
      end
      if (!got) begin
         n_checks++;
         n_fails++;
         $display("FAIL ack_timeout req%0d: no ack after %0d cycles, ack required", r, lat);
      end
      rd = (r == 0) ? a_rdata : b_rdata;
      @(posedge clk); #1;
      if (r == 0) a_req = 1'b0; else b_req = 1'b0;
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1;
      rst = 1'b1;
      #2 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat_a, lat_b, lat;
      logic [7:0] rd_a, rd_b, rd;
      int         snap;
      rst = 1'b1;
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_busy",     busy,     1'b0);
      chk("rst_ram_we",   ram_we,   1'b0);
      chk("rst_ram_addr", ram_addr, 4'h0);
      chk("rst_a_ack",    a_ack,    1'b0);
      chk("rst_b_ack",    b_ack,    1'b0);
      chk("rst_a_rdata",  a_rdata,  8'h00);
      chk("rst_b_rdata",  b_rdata,  8'h00);

      // Single write then read by A.
      do_cmd(0, 1'b1, 4'd3, 8'hA5, lat, rd);
      chk("a_wr_latency", lat, 2);
      do_cmd(0, 1'b0, 4'd3, 8'h00, lat, rd);
      chk("a_rd_latency", lat, 3);
      chk("a_rd_data", rd, 8'hA5);
      chk("b_ack_silent", b_ack_cnt, 0);

      // Simultaneous writes straight after reset: A first.
      pulse_rst();
      order.delete();
      fork
         do_cmd(0, 1'b1, 4'd1, 8'h11, lat_a, rd_a);
         do_cmd(1, 1'b1, 4'd2, 8'h22, lat_b, rd_b);
      join
      chk("tie_count", order.size(), 2);
      if (order.size() == 2) begin
         chk("tie_first",  order[0], 0);
         chk("tie_second", order[1], 1);
      end
      do_cmd(0, 1'b0, 4'd1, 8'h00, lat, rd);
      chk("tie_rb_a", rd, 8'h11);
      do_cmd(1, 1'b0, 4'd2, 8'h00, lat, rd);
      chk("tie_rb_b", rd, 8'h22);

      // Continuous contention: six reads each, req held throughout.
      pulse_rst();
      order.delete();
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               do_cmd(0, 1'b0, 4'(i), 8'h00, lat_a, rd_a);
`ifndef RAM_ARB_FIXED_PRIO_EN
               chk("cont_wait_a", (lat_a <= 7), 1'b1);
`endif
            end
         end
         begin
            for (int j = 0; j < 6; j++) begin
               do_cmd(1, 1'b0, 4'(8 + j), 8'h00, lat_b, rd_b);
`ifndef RAM_ARB_FIXED_PRIO_EN
               chk("cont_wait_b", (lat_b <= 7), 1'b1);
`endif
            end
         end
      join
      chk("cont_count", order.size(), 12);
      for (int k = 0; k < 12; k++) begin
         if (k < order.size()) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            chk("cont_order", order[k], (k < 6) ? 0 : 1);
`else
            chk("cont_order", order[k], k % 2);
`endif
         end
      end

      // Random mixed traffic from both requesters.
      fork
         begin
            for (int i = 0; i < 10; i++)
               do_cmd(0, 1'($urandom_range(1)), 4'($urandom_range(15)),
                      8'($urandom_range(255)), lat_a, rd_a);
         end
         begin
            for (int j = 0; j < 10; j++)
               do_cmd(1, 1'($urandom_range(1)), 4'($urandom_range(15)),
                      8'($urandom_range(255)), lat_b, rd_b);
         end
      join

      // Address and data extremes.
      do_cmd(0, 1'b1, 4'd0,  8'h00, lat, rd);
      do_cmd(0, 1'b1, 4'd15, 8'hFF, lat, rd);
      do_cmd(1, 1'b0, 4'd15, 8'h00, lat, rd);
      chk("wrap_rd15", rd, 8'hFF);
      do_cmd(1, 1'b0, 4'd0,  8'h00, lat, rd);
      chk("wrap_rd0", rd, 8'h00);

      // Reset during the ACCESS cycle of a B write.
      do_cmd(0, 1'b1, 4'd7, 8'h99, lat, rd);
      snap = b_ack_cnt;
      b_we = 1'b1; b_addr = 4'd7; b_wdata = 8'h3C; b_req = 1'b1;
      @(posedge clk); #1;
      chk("abort_ram_we_before", ram_we, 1'b1);
      rst = 1'b1;
      #1;
      chk("abort_busy",     busy,     1'b0);
      chk("abort_ram_we",   ram_we,   1'b0);
      chk("abort_ram_addr", ram_addr, 4'h0);
      b_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_b_ack", b_ack_cnt, snap);
      chk("abort_idle", busy, 1'b0);
      do_cmd(0, 1'b0, 4'd7, 8'h00, lat, rd);
      chk("abort_rd7", rd, 8'h99);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
